// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage.
//   state_t            : fetch FSM states (BOOT, RUN, HALT)
//   CAUSE_*            : fault cause encodings reported on fault_cause
//   IMM_W / JIDX_W     : instruction immediate and jump-index field widths
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned JIDX_W = 26;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux and target arithmetic (combinational).
// Ports:
//   pc_plus4      in  32  sequential successor of the current pc
//   jump_reg      in  1   select jr_target (highest priority)
//   jr_target     in  32  register jump byte address
//   jump          in  1   select the J-type target
//   jump_index    in  26  J-type target field
//   branch_taken  in  1   select the PC-relative branch target
//   branch_offset in  16  signed word offset
//   target        out 32  selected next pc
//   misalign      out 1   target[1:0] is non-zero
//   range_err     out 1   target word address is outside the instruction memory
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 16
) (
  input  logic [31:0]       pc_plus4,
  input  logic              jump_reg,
  input  logic [31:0]       jr_target,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  branch_offset,
  output logic [31:0]       target,
  output logic              misalign,
  output logic              range_err
);

  logic [31:0] branch_disp;

  // Sign-extend the word offset, then scale to bytes.
  assign branch_disp = {{(32-IMM_W-2){branch_offset[IMM_W-1]}}, branch_offset, 2'b00};

  always_comb begin
    target = pc_plus4;
    if (jump_reg)
      target = jr_target;
    else if (jump)
      target = {pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      target = pc_plus4 + branch_disp;
  end

  assign misalign  = (target[1:0] != 2'b00);
  assign range_err = ({2'b00, target[31:2]} >= 32'(IMEM_WORDS));

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch control.
// Holds the architectural PC, sequences BOOT/RUN/HALT, applies the next-PC
// selection with alignment/range checking, captures the first fault and
// counts fetched instructions.
// Ports:
//   clk, rst (async, active-high)
//   stall, branch_taken/branch_offset, jump/jump_index, jump_reg/jr_target, halt_req : controls
//   pc, pc_plus4      : current pc and its sequential successor
//   fetch_valid       : instruction at pc executes this cycle
//   fault, fault_cause, fault_pc : sticky first-fault record
//   inst_count        : fetched instruction counter (wraps)
//   halted            : FSM is in HALT
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0020,
  parameter int unsigned IMEM_WORDS   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [IMM_W-1:0]  branch_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jump_reg,
  input  logic [31:0]       jr_target,
  input  logic              halt_req,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              fetch_valid,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic [31:0]       fault_pc,
  output logic [31:0]       inst_count,
  output logic              halted
);

  state_t      state, next_state;
  logic        advance;
  logic [31:0] target;
  logic        misalign, range_err;

  assign pc_plus4 = pc + 32'd4;

  next_pc_sel #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_sel (
    .pc_plus4      (pc_plus4),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .jump          (jump),
    .jump_index    (jump_index),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .target        (target),
    .misalign      (misalign),
    .range_err     (range_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    fetch_valid = 1'b0;
    advance     = 1'b0;
    halted      = 1'b0;
    case (state)
      BOOT: next_state = RUN;
      RUN: begin
        fetch_valid = !stall;
        if (halt_req)   next_state = HALT;
        else if (!stall) advance = 1'b1;
      end
      HALT: halted = 1'b1;
      default: next_state = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      fault_pc    <= '0;
    end else if (advance) begin
      if (misalign || range_err) begin
        pc <= TRAP_VECTOR;
        // Only the first fault is recorded; misalignment outranks range.
        if (!fault) begin
          fault       <= 1'b1;
          fault_cause <= misalign ? CAUSE_MISALIGN : CAUSE_RANGE;
          fault_pc    <= pc;
        end
      end else begin
        pc <= target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              inst_count <= '0;
    else if (fetch_valid) inst_count <= inst_count + 32'd1;
  end

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_target = '0;
  logic        halt_req = 1'b0;
  logic [31:0] pc, pc_plus4, fault_pc, inst_count;
  logic        fetch_valid, fault, halted;
  logic [1:0]  fault_cause;

  int vectors = 0;
  int miscompares = 0;

  pc_fetch #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0020),
    .IMEM_WORDS   (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .halt_req      (halt_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid),
    .fault         (fault),
    .fault_cause   (fault_cause),
    .fault_pc      (fault_pc),
    .inst_count    (inst_count),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_taken = 0; branch_offset = '0; jump = 0;
    jump_index = '0; jump_reg = 0; jr_target = '0; halt_req = 0;
  endtask

  // Pulse reset away from the clock edge; leaves the DUT in its BOOT cycle.
  task automatic pulse_reset();
    clear_inputs();
    rst = 1; #2; rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; tick(); rst = 0;
    tick(); tick(); tick();
    // Asynchronous reset mid-cycle
    #2; rst = 1; #1;
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
    vectors++; if (inst_count !== 32'h0) begin miscompares++; $display("FAIL reset_count got %0d want 0", inst_count); end
    vectors++; if (fault !== 1'b0 || fault_cause !== 2'b00 || fault_pc !== 32'h0 || halted !== 1'b0)
      begin miscompares++; $display("FAIL reset_flags got f=%b c=%b fpc=%h h=%b want 0 00 0 0", fault, fault_cause, fault_pc, halted); end
    #1; rst = 0;
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL boot_valid got %b want 0", fetch_valid); end
    tick();
    vectors++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin miscompares++; $display("FAIL run0 got pc=%h v=%b want 0 1", pc, fetch_valid); end
    tick();
    vectors++; if (pc !== 32'h4 || pc_plus4 !== 32'h8) begin miscompares++; $display("FAIL run4 got pc=%h p4=%h want 4 8", pc, pc_plus4); end
    tick();
    vectors++; if (pc !== 32'h8 || inst_count !== 32'd2) begin miscompares++; $display("FAIL run8 got pc=%h cnt=%0d want 8 2", pc, inst_count); end
  endtask

  task automatic test_branch();
    branch_taken = 1; branch_offset = 16'h0001;
    tick();
    vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL branch_fwd got %h want %h", pc, 32'h10); end
    branch_offset = 16'hFFFE;
    tick();
    vectors++; if (pc !== 32'hC) begin miscompares++; $display("FAIL branch_back got %h want %h", pc, 32'hC); end
    clear_inputs();
  endtask

  task automatic test_priority();
    pulse_reset(); tick(); tick();
    jump_reg = 1; jr_target = 32'h20; jump = 1; jump_index = 26'd3; branch_taken = 1; branch_offset = 16'h0002;
    stall = 1; #1;
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall_valid got %b want 0", fetch_valid); end
    tick();
    vectors++; if (pc !== 32'h4) begin miscompares++; $display("FAIL stall_hold got %h want %h", pc, 32'h4); end
    stall = 0;
    tick();
    vectors++; if (pc !== 32'h20 || fault !== 1'b0) begin miscompares++; $display("FAIL prio_jr got pc=%h f=%b want 20 0", pc, fault); end
    jump_reg = 0;
    tick();
    vectors++; if (pc !== 32'hC) begin miscompares++; $display("FAIL prio_jump got %h want %h", pc, 32'hC); end
    clear_inputs();
  endtask

  task automatic test_faults();
    pulse_reset(); tick(); tick(); tick(); tick();
    jump_reg = 1; jr_target = 32'h22;
    tick();
    vectors++; if (pc !== 32'h20 || fault !== 1'b1 || fault_cause !== 2'b01 || fault_pc !== 32'hC)
      begin miscompares++; $display("FAIL misalign got pc=%h f=%b c=%b fpc=%h want 20 1 01 c", pc, fault, fault_cause, fault_pc); end
    clear_inputs();
    tick();
    vectors++; if (pc !== 32'h24) begin miscompares++; $display("FAIL after_trap got %h want %h", pc, 32'h24); end
    jump = 1; jump_index = 26'd100;
    tick();
    vectors++; if (pc !== 32'h20 || fault_cause !== 2'b01 || fault_pc !== 32'hC)
      begin miscompares++; $display("FAIL sticky got pc=%h c=%b fpc=%h want 20 01 c", pc, fault_cause, fault_pc); end
    // Last legal word, then sequential step off the end
    pulse_reset(); tick();
    jump_reg = 1; jr_target = 32'h3C;
    tick();
    vectors++; if (pc !== 32'h3C || fault !== 1'b0) begin miscompares++; $display("FAIL last_word got pc=%h f=%b want 3c 0", pc, fault); end
    clear_inputs();
    tick();
    vectors++; if (pc !== 32'h20 || fault_cause !== 2'b10 || fault_pc !== 32'h3C)
      begin miscompares++; $display("FAIL range got pc=%h c=%b fpc=%h want 20 10 3c", pc, fault_cause, fault_pc); end
    // Both misaligned and out of range: misaligned reported
    pulse_reset(); tick();
    jump_reg = 1; jr_target = 32'h43;
    tick();
    vectors++; if (pc !== 32'h20 || fault_cause !== 2'b01 || fault_pc !== 32'h0)
      begin miscompares++; $display("FAIL both got pc=%h c=%b fpc=%h want 20 01 0", pc, fault_cause, fault_pc); end
    clear_inputs();
  endtask

  task automatic test_halt();
    pulse_reset(); tick(); tick(); tick();
    halt_req = 1; stall = 1; branch_taken = 1; branch_offset = 16'h0004;
    tick();
    vectors++; if (halted !== 1'b1 || pc !== 32'h8 || fetch_valid !== 1'b0 || inst_count !== 32'd2)
      begin miscompares++; $display("FAIL halt_enter got h=%b pc=%h v=%b cnt=%0d want 1 8 0 2", halted, pc, fetch_valid, inst_count); end
    halt_req = 0; stall = 0; jump_reg = 1; jr_target = 32'h10;
    tick(); tick(); tick();
    vectors++; if (halted !== 1'b1 || pc !== 32'h8 || fetch_valid !== 1'b0 || inst_count !== 32'd2)
      begin miscompares++; $display("FAIL halt_hold got h=%b pc=%h v=%b cnt=%0d want 1 8 0 2", halted, pc, fetch_valid, inst_count); end
    clear_inputs();
  endtask

  task automatic test_wrap();
    pulse_reset(); tick();
    force dut.inst_count = 32'hFFFF_FFFF;
    #1;
    release dut.inst_count;
    tick();
    vectors++; if (inst_count !== 32'h0 || pc !== 32'h4) begin miscompares++; $display("FAIL wrap got cnt=%h pc=%h want 0 4", inst_count, pc); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_faults();
    test_halt();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
